// File: rtl/io_bist_pkg.sv
// rtl/io_bist_pkg.sv - state type, default polynomials and Galois step shared by the IO BIST engine
package io_bist_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  localparam logic [63:0] POLY8       = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] POLY16      = 64'h0000_0000_0000_B400;
  localparam logic [63:0] POLY32      = 64'h0000_0000_8020_0003;
  localparam logic [15:0] MISR_POLY16 = 16'h8408;

  function automatic logic [63:0] default_poly(input int w);
    case (w)
      16:      return POLY16;
      32:      return POLY32;
      default: return POLY8;
    endcase
  endfunction

  // Right-shifting Galois step; callers zero-extend and truncate to their own width.
  function automatic logic [63:0] lfsr_step(input logic [63:0] v, input logic [63:0] poly);
    return (v >> 1) ^ (v[0] ? poly : 64'd0);
  endfunction

endpackage

// File: rtl/io_bist_lfsr.sv
// rtl/io_bist_lfsr.sv - Galois shift register with load, step and XOR-in (stimulus generator or MISR)
module io_bist_lfsr
  import io_bist_pkg::*;
#(
  parameter int             W    = 8,
  parameter logic [W-1:0]   POLY = W'(8'hB8)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic [W-1:0] xor_in,
  output logic [W-1:0] value
);

  logic [W-1:0] stepped;

  assign stepped = W'(lfsr_step(64'(value), 64'(POLY)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (step) begin
      value <= stepped ^ xor_in;
    end
  end

endmodule

// File: rtl/io_bist_engine.sv
// rtl/io_bist_engine.sv - LFSR stimulus / MISR response self-test engine with golden compare
// Optional abort on a stalled DUT is built when IO_BIST_TIMEOUT_EN is defined.
module io_bist_engine
  import io_bist_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter int                 NUM_VEC   = 256,
  parameter logic [WIDTH-1:0]   LFSR_POLY = WIDTH'(default_poly(WIDTH)),
  parameter logic [WIDTH-1:0]   SEED      = WIDTH'(1),
  parameter int                 SIG_W     = 16,
  parameter logic [SIG_W-1:0]   SIG_POLY  = SIG_W'(MISR_POLY16),
  parameter int                 TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [WIDTH-1:0] stim,
  output logic             stim_valid,
  input  logic             stim_ready,
  input  logic [WIDTH-1:0] resp,
  input  logic             resp_valid,
  input  logic [SIG_W-1:0] golden_sig,
  output logic [SIG_W-1:0] signature
);

  localparam int                 CNT_W    = $clog2(NUM_VEC + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(NUM_VEC);
  localparam logic [WIDTH-1:0]   SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  if (WIDTH < 2 || WIDTH > 32 || NUM_VEC < 1 || SIG_W < WIDTH || SIG_W > 64 || TIMEOUT < 1)
  begin : g_bad_params
    $error("io_bist_engine: illegal parameter set");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] sent, rcvd;
  logic             in_run, in_drain, load_st;
  logic             stim_acc, resp_acc;
  logic             idle_hit;
  logic [WIDTH-1:0] lfsr;
  logic [SIG_W-1:0] misr;

  assign load_st  = (state == LOAD);
  assign in_run   = (state == RUN);
  assign in_drain = (state == DRAIN);
  assign stim_acc = in_run && stim_ready;
  // Responses are taken in RUN as well, so a zero-latency DUT is compacted correctly.
  assign resp_acc = (in_run || in_drain) && resp_valid && (rcvd != CNT_FULL);

  io_bist_lfsr #(.W(WIDTH), .POLY(LFSR_POLY)) u_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load_st),
    .load_val (SEED_EFF),
    .step     (stim_acc),
    .xor_in   ('0),
    .value    (lfsr)
  );

  io_bist_lfsr #(.W(SIG_W), .POLY(SIG_POLY)) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (load_st),
    .load_val ('0),
    .step     (resp_acc),
    .xor_in   (SIG_W'(resp)),
    .value    (misr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent <= '0;
      rcvd <= '0;
    end else if (load_st) begin
      sent <= '0;
      rcvd <= '0;
    end else begin
      if (stim_acc) sent <= sent + CNT_W'(1);
      if (resp_acc) rcvd <= rcvd + CNT_W'(1);
    end
  end

`ifdef IO_BIST_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              timed_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (load_st || stim_acc || resp_acc) begin
      idle_cnt <= '0;
    end else if (in_run || in_drain) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // Fires on the idle cycle that brings the count to TIMEOUT, so the counter never wraps.
  assign idle_hit = (in_run || in_drain) && !stim_acc && !resp_acc &&
                    (idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timed_out <= 1'b0;
    end else if (load_st) begin
      timed_out <= 1'b0;
    end else if (idle_hit) begin
      timed_out <= 1'b1;
    end
  end

  assign timeout = timed_out;
`else
  assign idle_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  state_nxt = RUN;
      RUN: begin
        if (idle_hit)                          state_nxt = DONE;
        else if (stim_acc && sent == CNT_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (idle_hit || rcvd == CNT_FULL || (resp_acc && rcvd == CNT_LAST))
          state_nxt = DONE;
      end
      DONE:  if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = load_st || in_run || in_drain;
  assign done       = (state == DONE);
  assign pass       = done && !timeout && (misr == golden_sig);
  assign stim       = lfsr;
  assign stim_valid = in_run;
  assign signature  = misr;

endmodule

// File: tb/tb_io_bist_engine.sv
// tb/tb_io_bist_engine.sv - randomized reference-model bench for io_bist_engine (4- and 256-vector builds)
`timescale 1ns/1ps
module tb_io_bist_engine;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start, busy, done, pass, timeout, stim_valid, stim_ready, resp_valid;
  logic [7:0]  stim [2];
  logic [7:0]  resp [2];
  logic [15:0] golden_sig [2];
  logic [15:0] signature [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  io_bist_engine #(.NUM_VEC(4), .TIMEOUT(TO)) u_dut4 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .timeout(timeout[0]), .stim(stim[0]), .stim_valid(stim_valid[0]), .stim_ready(stim_ready[0]),
    .resp(resp[0]), .resp_valid(resp_valid[0]), .golden_sig(golden_sig[0]), .signature(signature[0])
  );

  io_bist_engine #(.NUM_VEC(256), .TIMEOUT(TO)) u_dut256 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .timeout(timeout[1]), .stim(stim[1]), .stim_valid(stim_valid[1]), .stim_ready(stim_ready[1]),
    .resp(resp[1]), .resp_valid(resp_valid[1]), .golden_sig(golden_sig[1]), .signature(signature[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gen_next(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] m, input logic [7:0] d);
    return ((m >> 1) ^ (m[0] ? 16'h8408 : 16'h0000)) ^ {8'h00, d};
  endfunction

  logic [7:0] obs [4];

  // Plays the DUT side: loops accepted stimuli back after a random latency, optionally
  // dropping one response. cyc 0 is the LOAD cycle.
  task automatic run_unit(input int u, input int lat_lo, input int lat_hi, input bit toggle,
                          input int drop, input bit poke_start, input int budget,
                          output logic [15:0] sig_m, output int n_acc, output int t_load,
                          output int t_last);
    logic [7:0] lfsr_m;
    logic [7:0] q_d [$];
    int         q_t [$];
    int         n_rsp, cyc, last_ev;
    bit         stalled;
    logic [7:0] held;
    lfsr_m = 8'h01; sig_m = '0; n_acc = 0; n_rsp = 0; cyc = 0; last_ev = 0;
    stalled = 1'b0; held = '0;
    start[u] = 1'b1;
    @(posedge clk); #1;
    start[u] = 1'b0;
    check("load_flags_low", {done[u], pass[u], timeout[u]}, 3'b000);
    check("load_busy", busy[u], 1'b1);
    while (!done[u] && cyc < budget) begin
      stim_ready[u] = toggle ? cyc[0] : 1'b1;
      start[u] = poke_start && (cyc == 3);
      if (stalled) check("stall_hold", stim[u], held);
      if (stim_valid[u] && stim_ready[u]) begin
        check("stim", stim[u], lfsr_m);
        if (n_acc < 4) obs[n_acc] = stim[u];
        q_d.push_back(lfsr_m);
        q_t.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
        lfsr_m = gen_next(lfsr_m);
        n_acc++;
        last_ev = cyc;
      end
      stalled = stim_valid[u] && !stim_ready[u];
      held = stim[u];
      resp_valid[u] = 1'b0;
      resp[u] = 8'($urandom);
      if (q_d.size() > 0 && q_t[0] <= cyc) begin
        if (n_rsp != drop) begin
          resp_valid[u] = 1'b1;
          resp[u] = q_d[0];
          sig_m = misr_next(sig_m, q_d[0]);
          last_ev = cyc;
        end
        void'(q_d.pop_front());
        void'(q_t.pop_front());
        n_rsp++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    resp_valid[u] = 1'b0;
    start[u] = 1'b0;
    stim_ready[u] = 1'b0;
    t_load = cyc;
    t_last = cyc - last_ev;
  endtask

  logic [15:0] sig_a, sig_b, m;
  int          nacc, tl, tlast;
  logic [7:0]  exp4 [4];

  initial begin
    exp4 = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
    start = '0; stim_ready = '0; resp_valid = '0;
    resp[0] = '0; resp[1] = '0; golden_sig[0] = '0; golden_sig[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rst_flags", {busy[u], done[u], pass[u], timeout[u], stim_valid[u]}, 5'b0);
      check("rst_stim", stim[u], 8'h00);
      check("rst_sig", signature[u], 16'h0000);
    end
    rst = 1'b0;

    // Responses offered while idle must not reach the MISR.
    for (int i = 0; i < 5; i++) begin
      resp_valid[0] = 1'b1; resp[0] = 8'($urandom | 1);
      @(posedge clk); #1;
    end
    resp_valid[0] = 1'b0;
    check("idle_resp_ignored", signature[0], 16'h0000);

    // Four-vector loopback run, 1-cycle latency.
    run_unit(0, 1, 1, 1'b0, -1, 1'b0, 100, sig_a, nacc, tl, tlast);
    check("run4_done", done[0], 1'b1);
    check("run4_load_to_done", tl, 6);
    check("run4_sig", signature[0], sig_a);
    check("run4_nacc", nacc, 4);
    for (int i = 0; i < 4; i++) check("run4_seq", obs[i], exp4[i]);
    golden_sig[0] = sig_a; #1;
    check("pass_golden", pass[0], 1'b1);
    golden_sig[0] = sig_a ^ 16'h0001; #1;
    check("pass_bad_golden", pass[0], 1'b0);
    golden_sig[0] = sig_a;

    // Responses in DONE must not disturb the frozen signature.
    for (int i = 0; i < 5; i++) begin
      resp_valid[0] = 1'b1; resp[0] = 8'($urandom | 1);
      @(posedge clk); #1;
    end
    resp_valid[0] = 1'b0;
    check("done_resp_ignored", signature[0], sig_a);
    check("done_held", done[0], 1'b1);

    // Rerun from DONE with a stray start during RUN.
    run_unit(0, 1, 1, 1'b0, -1, 1'b1, 100, sig_b, nacc, tl, tlast);
    check("rerun_done", done[0], 1'b1);
    check("rerun_load_to_done", tl, 6);
    check("rerun_sig", signature[0], sig_b);
    check("rerun_same_sig", signature[0], sig_a);
    check("rerun_pass", pass[0], 1'b1);

    // 256 vectors, stalled every other cycle, random response latency 0..5.
    run_unit(1, 0, 5, 1'b1, -1, 1'b0, 3000, sig_b, nacc, tl, tlast);
    check("run256_done", done[1], 1'b1);
    check("run256_nacc", nacc, 256);
    check("run256_sig", signature[1], sig_b);

    // Reset after three accepts.
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0; stim_ready[0] = 1'b1; resp_valid[0] = 1'b1; resp[0] = 8'h5A;
    repeat (4) @(posedge clk);
    #1;
    m = '0;
    for (int i = 0; i < 3; i++) m = misr_next(m, 8'h5A);
    check("pre_rst_sig", signature[0], m);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrun_rst_busy", busy[0], 1'b0);
    check("midrun_rst_valid", stim_valid[0], 1'b0);
    check("midrun_rst_sig", signature[0], 16'h0000);
    rst = 1'b0; stim_ready[0] = 1'b0; resp_valid[0] = 1'b0;
    @(posedge clk); #1;

    // Third response never arrives.
    run_unit(0, 1, 1, 1'b0, 2, 1'b0, 100, sig_a, nacc, tl, tlast);
    golden_sig[0] = sig_a; #1;
`ifdef IO_BIST_TIMEOUT_EN
    check("to_done", done[0], 1'b1);
    check("to_idle_cycles", tlast, TO + 1);
    check("to_flag", timeout[0], 1'b1);
    check("to_pass", pass[0], 1'b0);
`else
    check("noto_busy", busy[0], 1'b1);
    check("noto_done", done[0], 1'b0);
    check("noto_flag", timeout[0], 1'b0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
